product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 84 ++++++++
 tb/tb_product_accumulator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums unsigned 8-bit multiplier products into saturating groups and
// presents each completed group result through a valid/ready output.
module product_accumulator #(
  parameter int ACC_W     = 12,
  parameter int MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_sum,
  output logic [4:0]       acc_count,
  output logic             overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [4:0]       MAX_CNT = 5'(MAX_TERMS);
  localparam logic [ACC_W-1:0] SAT     = '1;

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_sum;
  logic [4:0]       r_count;
  logic             r_ovf;

  logic [ACC_W:0]   w_add;
  logic [4:0]       w_cnt_nxt;
  logic             w_close;

  // One extra bit catches the carry that triggers saturation.
  assign w_add     = {1'b0, r_sum} + (ACC_W+1)'(product);
  assign w_cnt_nxt = r_count + 5'd1;
  assign w_close   = in_last || (w_cnt_nxt == MAX_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sum   <= ACC_W'(product);
            r_count <= 5'd1;
            r_ovf   <= 1'b0;
            if (in_last || MAX_TERMS == 1)
              r_state <= S_HOLD;
            else
              r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_sum   <= w_add[ACC_W] ? SAT : w_add[ACC_W-1:0];
            r_ovf   <= r_ovf | w_add[ACC_W];
            r_count <= w_cnt_nxt;
            if (w_close)
              r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state != S_HOLD);
  assign out_valid = (r_state == S_HOLD);
  assign acc_sum   = r_sum;
  assign acc_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed group scenarios plus a
// randomized handshake run checked against a group-level sum model.
module tb_product_accumulator;

  localparam int W    = 12;
  localparam int MAXT = 16;
  localparam int SATV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   product = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] acc_sum;
  logic [4:0]   acc_count;
  logic         overflow;

  logic         b_in_valid = 1'b0;
  logic         b_in_ready;
  logic [7:0]   b_product = '0;
  logic         b_in_last = 1'b0;
  logic         b_out_valid;
  logic         b_out_ready = 1'b0;
  logic [7:0]   b_acc_sum;
  logic [4:0]   b_acc_count;
  logic         b_overflow;

  int n_vec = 0;
  int n_err = 0;

  bit m_hold = 0;
  int m_sum  = 0;
  int m_cnt  = 0;
  int n_groups = 0;

  always #5 clk = ~clk;

  product_accumulator #(.ACC_W(W), .MAX_TERMS(MAXT)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .product(product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_sum(acc_sum), .acc_count(acc_count),
    .overflow(overflow)
  );

  product_accumulator #(.ACC_W(8), .MAX_TERMS(MAXT)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .product(b_product), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_sum(b_acc_sum), .acc_count(b_acc_count),
    .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_hold));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
    if (m_hold) begin
      chk({tag, ".sum"}, 32'(acc_sum), (m_sum > SATV) ? SATV : m_sum);
      chk({tag, ".count"}, 32'(acc_count), m_cnt);
      chk({tag, ".ovf"}, 32'(overflow), 32'(m_sum > SATV));
    end
  endtask

  // Apply one cycle of main-DUT inputs, advance the model, then check.
  task automatic step(input bit v, input logic [7:0] p, input bit l,
                      input bit ordy, input string tag);
    in_valid  = v;
    product   = p;
    in_last   = l;
    out_ready = ordy;
    if (m_hold) begin
      if (ordy) begin
        m_hold = 0;
        m_sum  = 0;
        m_cnt  = 0;
        n_groups++;
      end
    end else if (v) begin
      m_sum += int'(p);
      m_cnt++;
      if (l || m_cnt == MAXT) m_hold = 1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".sum"}, 32'(acc_sum), 0);
    chk({tag, ".count"}, 32'(acc_count), 0);
    chk({tag, ".ovf"}, 32'(overflow), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    int cyc;
    bit v, l, r;

    #2;
    check_zero("rst0");
    chk("rst0.b_in_ready", 32'(b_in_ready), 1);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    step(1, 8'd15, 0, 0, "r31a");
    step(1, 8'd225, 0, 0, "r31b");
    step(1, 8'd36, 1, 0, "r31c");
    chk("r31.sum", 32'(acc_sum), 276);
    chk("r31.count", 32'(acc_count), 3);
    step(0, 8'd0, 0, 1, "r31rel");

    for (int i = 0; i < 16; i++) step(1, 8'd225, 0, 0, "r32acc");
    chk("r32.sum", 32'(acc_sum), 3600);
    chk("r32.count", 32'(acc_count), 16);
    chk("r32.ovf", 32'(overflow), 0);
    step(0, 8'd0, 0, 1, "r32rel");
    step(1, 8'd9, 1, 0, "r32b");
    chk("r32b.sum", 32'(acc_sum), 9);
    chk("r32b.count", 32'(acc_count), 1);

    // Held result must stay put and refuse a waiting product.
    for (int i = 0; i < 10; i++) step(1, 8'd77, 0, 0, "r34hold");
    step(1, 8'd77, 0, 1, "r34xfer");
    step(1, 8'd77, 1, 0, "r34next");
    chk("r34.sum", 32'(acc_sum), 77);
    step(0, 8'd0, 0, 1, "r34rel");

    step(1, 8'd0, 0, 0, "zero_a");
    step(1, 8'd0, 1, 0, "zero_b");
    chk("zero.count", 32'(acc_count), 2);
    step(0, 8'd0, 0, 1, "zero_rel");

    b_in_valid = 1; b_product = 8'd200; b_in_last = 0;
    step(0, 8'd0, 0, 0, "r33a");
    b_product = 8'd100; b_in_last = 1;
    step(0, 8'd0, 0, 0, "r33b");
    b_in_valid = 0; b_in_last = 0;
    chk("r33.out_valid", 32'(b_out_valid), 1);
    chk("r33.sum", 32'(b_acc_sum), 255);
    chk("r33.ovf", 32'(b_overflow), 1);
    chk("r33.count", 32'(b_acc_count), 2);
    b_out_ready = 1;
    step(0, 8'd0, 0, 0, "r33rel");
    b_out_ready = 0;
    chk("r33.rel_valid", 32'(b_out_valid), 0);
    b_in_valid = 1; b_product = 8'd5; b_in_last = 1;
    step(0, 8'd0, 0, 0, "r33c");
    b_in_valid = 0; b_in_last = 0;
    chk("r33c.sum", 32'(b_acc_sum), 5);
    chk("r33c.ovf", 32'(b_overflow), 0);
    b_out_ready = 1;
    step(0, 8'd0, 0, 0, "r33crel");
    b_out_ready = 0;

    // Asynchronous reset between edges, mid-group.
    step(1, 8'd10, 0, 0, "r36a");
    step(1, 8'd20, 0, 0, "r36b");
    in_valid = 0;
    #3;
    rst = 1'b1;
    #1;
    check_zero("r36rst");
    m_hold = 0; m_sum = 0; m_cnt = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(1, 8'd7, 1, 0, "r36new");
    chk("r36.sum", 32'(acc_sum), 7);

    // Reset while holding drops the pending result.
    #3;
    rst = 1'b1;
    #1;
    check_zero("r29rst");
    m_hold = 0; m_sum = 0; m_cnt = 0;
    #2;
    rst = 1'b0;
    step(0, 8'd0, 0, 1, "r29idle");

    n_groups = 0;
    cyc = 0;
    while (n_groups < 1000 && cyc < 60000) begin
      v = ($urandom_range(0, 99) < 60);
      l = ($urandom_range(0, 99) < 25);
      r = ($urandom_range(0, 99) < 50);
      step(v, 8'($urandom), l, r, "rand");
      cyc++;
    end
    chk("rand.groups_done", n_groups, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
